delay_arbiter: RTL and testbench
================================

DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter: WDOG_CYCLES, default 32'd2_000_000, watchdog limit in CLK cycles (used only under DLY_ARB_WDOG_EN).
REQ-003 Port: CLK  input  1  system clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-low.
REQ-005 Port: REQ  input  N_REQ  per-requester delay request; level, held until FIN seen.
REQ-006 Port: REQ_MS  input  12*N_REQ  packed requested delays in ms; slice i = bits [12*i+11:12*i].
REQ-007 Port: GNT  output  N_REQ  one-hot grant, registered.
REQ-008 Port: FIN  output  N_REQ  one-hot delay-complete, registered.
REQ-009 Port: BUSY  output  1  high in any state other than IDLE.
REQ-010 Port: TMR_MS  output  12  delay value to the shared ms timer, registered.
REQ-011 Port: TMR_EN  output  1  enable to the shared ms timer, registered.
REQ-012 Port: TMR_FIN  input  1  done flag from the shared ms timer; may fall combinationally when TMR_EN falls.
REQ-013 Port: ERR  output  1  watchdog abort pulse (present only under DLY_ARB_WDOG_EN).

Function
REQ-014 States: IDLE, RUN, DONE, RELEASE; exactly one active.
REQ-015 IDLE: on an edge where any REQ bit is high, winner = first set index searching from LAST+1 upward, modulo N_REQ; same edge: GNT[winner]=1, TMR_MS=REQ_MS[winner], TMR_EN=1, state -> RUN.
REQ-016 Grant latency: one cycle from REQ sampled high in IDLE to GNT/TMR_EN high.
REQ-017 TMR_MS is latched only at grant; REQ_MS changes during RUN/DONE are ignored.
REQ-018 RUN: TMR_FIN=1 -> FIN[winner]=1, state -> DONE; TMR_EN stays 1.
REQ-019 RUN: REQ[winner]=0 before TMR_FIN (abort) -> TMR_EN=0, GNT=0, no FIN, state -> RELEASE; abort takes priority over simultaneous TMR_FIN.
REQ-020 DONE: FIN[winner] and GNT[winner] held until REQ[winner]=0; then FIN=0, GNT=0, TMR_EN=0, state -> RELEASE.
REQ-021 RELEASE: stay while TMR_FIN=1; when TMR_FIN=0, LAST=winner, state -> IDLE; minimum one cycle in RELEASE.
REQ-022 New requests arriving in RUN/DONE/RELEASE are held pending and arbitrated only in IDLE; no requester is granted twice in a row while another is pending.
REQ-023 REQ_MS=0 is legal; block waits for TMR_FIN as usual.
REQ-024 At most one GNT bit and one FIN bit high in any cycle; FIN implies GNT of same index.

Reset
REQ-025 RST low asynchronously forces: state IDLE, GNT=0, FIN=0, TMR_EN=0, TMR_MS=0, BUSY=0, ERR=0, LAST=N_REQ-1 (so index 0 wins first).
REQ-026 RST asserted mid-RUN drops TMR_EN immediately; no FIN is produced for the interrupted request.
REQ-027 Reset release is sampled synchronously; first arbitration at earliest on the first edge after release.

Configuration
REQ-028 Macro DLY_ARB_WDOG_EN defined: cycle counter clears on entry to RUN, increments each RUN cycle; reaching WDOG_CYCLES without TMR_FIN -> ERR=1 for one cycle, TMR_EN=0, GNT=0, no FIN, state -> RELEASE.
REQ-029 Macro DLY_ARB_WDOG_EN undefined: no counter, no ERR port; RUN waits indefinitely for TMR_FIN or abort.

Verification
REQ-030 Single request: REQ=4'b0001, REQ_MS[0]=3, timer model 1 ms=100 cycles -> GNT=0001 and TMR_MS=3 one cycle later, FIN[0] after ~300 cycles; drop REQ -> IDLE.
REQ-031 Round-robin: REQ=4'b1111 held, each dropped after FIN -> grant order 0,1,2,3,0.
REQ-032 Abort: grant req 2, drop REQ[2] mid-RUN -> TMR_EN=0 next cycle, FIN[2] never high, LAST=2.
REQ-033 Zero delay: REQ_MS[1]=0 -> FIN[1] within 2 cycles of TMR_EN, BUSY falls after REQ[1] drop plus RELEASE.
REQ-034 Async reset: RST low mid-RUN between edges -> GNT, TMR_EN, BUSY low before next edge; first post-reset grant to index 0.
REQ-035 With DLY_ARB_WDOG_EN, WDOG_CYCLES=50, TMR_FIN tied 0 -> ERR one-cycle pulse after 50 RUN cycles, GNT cleared, IDLE next.

Source files
------------

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that hands a single shared millisecond timer to N_REQ requesters.
// Optional watchdog abort is compiled in when DLY_ARB_WDOG_EN is defined.
module delay_arbiter #(
    parameter int          N_REQ       = 4,
    parameter logic [31:0] WDOG_CYCLES = 32'd2_000_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [12*N_REQ-1:0] REQ_MS,
    output logic [N_REQ-1:0]   GNT,
    output logic [N_REQ-1:0]   FIN,
    output logic               BUSY,
    output logic [11:0]        TMR_MS,
    output logic               TMR_EN,
    input  logic               TMR_FIN
`ifdef DLY_ARB_WDOG_EN
    ,
    output logic               ERR
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, RELEASE} state_t;

    state_t          state;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick;
    logic            found;
    int              idx;

`ifdef DLY_ARB_WDOG_EN
    logic [31:0]     wdog_cnt;
`endif

    assign BUSY = (state != IDLE);

    // Search upward from the requester after the previous owner, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && REQ[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            GNT    <= '0;
            FIN    <= '0;
            TMR_EN <= 1'b0;
            TMR_MS <= '0;
            winner <= '0;
            last   <= IW'(N_REQ - 1);
`ifdef DLY_ARB_WDOG_EN
            ERR      <= 1'b0;
            wdog_cnt <= '0;
`endif
        end else begin
`ifdef DLY_ARB_WDOG_EN
            ERR <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        winner <= pick;
                        GNT    <= N_REQ'(1) << pick;
                        TMR_MS <= REQ_MS[12*int'(pick) +: 12];
                        TMR_EN <= 1'b1;
                        state  <= RUN;
`ifdef DLY_ARB_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end
                end
                // A requester withdrawing its request wins over a timer that finishes on the same edge.
                RUN: begin
                    if (!REQ[winner]) begin
                        GNT    <= '0;
                        TMR_EN <= 1'b0;
                        state  <= RELEASE;
                    end else if (TMR_FIN) begin
                        FIN   <= N_REQ'(1) << winner;
                        state <= DONE;
                    end
`ifdef DLY_ARB_WDOG_EN
                    else if (wdog_cnt == WDOG_CYCLES - 32'd1) begin
                        ERR    <= 1'b1;
                        GNT    <= '0;
                        TMR_EN <= 1'b0;
                        state  <= RELEASE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 32'd1;
                    end
`endif
                end
                DONE: begin
                    if (!REQ[winner]) begin
                        FIN    <= '0;
                        GNT    <= '0;
                        TMR_EN <= 1'b0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!TMR_FIN) begin
                        last  <= winner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: transaction-level reference model, directed scenarios and random traffic.
// Define DLY_ARB_WDOG_EN to also exercise the watchdog abort.
module tb_delay_arbiter;

    localparam int          N    = 4;
    localparam logic [31:0] WDOG = 32'd400;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [N-1:0]     REQ = '0;
    logic [12*N-1:0]  REQ_MS = '0;
    logic [N-1:0]     GNT;
    logic [N-1:0]     FIN;
    logic             BUSY;
    logic [11:0]      TMR_MS;
    logic             TMR_EN;
    logic             TMR_FIN;
`ifdef DLY_ARB_WDOG_EN
    logic             ERR;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    delay_arbiter #(.N_REQ(N), .WDOG_CYCLES(WDOG)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_MS(REQ_MS),
        .GNT(GNT), .FIN(FIN), .BUSY(BUSY), .TMR_MS(TMR_MS),
        .TMR_EN(TMR_EN), .TMR_FIN(TMR_FIN)
`ifdef DLY_ARB_WDOG_EN
        , .ERR(ERR)
`endif
    );

    // Shared ms timer: done once TMR_MS * ms_cycles enabled cycles have elapsed.
    int ms_cycles = 4;
    bit tmr_dead  = 1'b0;
    int tcnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST)                tcnt <= 0;
        else if (!TMR_EN)        tcnt <= 0;
        else if (tcnt < 100000)  tcnt <= tcnt + 1;
    end
    assign TMR_FIN = TMR_EN && !tmr_dead && (tcnt >= int'(TMR_MS) * ms_cycles);

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the timer, whether it has finished, whether it is being released.
    int          m_owner, m_last, m_run;
    bit          m_fin, m_rel, m_en, m_err, m_found;
    logic [11:0] m_ms;
    int          m_idx;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_owner = -1; m_last = N - 1; m_run = 0;
            m_fin = 0; m_rel = 0; m_en = 0; m_err = 0; m_ms = '0;
        end else begin
            m_err = 0;
            if (m_owner < 0) begin
                m_found = 0;
                for (int k = 1; k <= N; k++) begin
                    m_idx = (m_last + k) % N;
                    if (!m_found && REQ[m_idx]) begin
                        m_found = 1;
                        m_owner = m_idx;
                        m_ms    = REQ_MS[12*m_idx +: 12];
                        m_en    = 1;
                        m_fin   = 0;
                        m_run   = 0;
                    end
                end
            end else if (m_rel) begin
                if (!TMR_FIN) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_rel   = 0;
                end
            end else if (!m_fin) begin
                if (!REQ[m_owner]) begin
                    m_en = 0; m_rel = 1;
                end else if (TMR_FIN) begin
                    m_fin = 1;
                end else begin
`ifdef DLY_ARB_WDOG_EN
                    m_run++;
                    if (m_run == int'(WDOG)) begin
                        m_err = 1; m_en = 0; m_rel = 1;
                    end
`endif
                end
            end else if (!REQ[m_owner]) begin
                m_fin = 0; m_en = 0; m_rel = 1;
            end
        end
    end

    function automatic logic [N-1:0] exp_gnt();
        return (m_owner >= 0 && !m_rel) ? N'(1) << m_owner : '0;
    endfunction

    function automatic logic [N-1:0] exp_fin();
        return (m_owner >= 0 && m_fin) ? N'(1) << m_owner : '0;
    endfunction

    // Every cycle out of reset, outputs must match the model and the one-hot rules.
    always @(negedge CLK) begin
        if (RST) begin
            check_output("gnt", 32'(GNT), 32'(exp_gnt()));
            check_output("fin", 32'(FIN), 32'(exp_fin()));
            check_output("busy", 32'(BUSY), 32'(m_owner >= 0));
            check_output("tmr_en", 32'(TMR_EN), 32'(m_en));
            check_output("tmr_ms", 32'(TMR_MS), 32'(m_ms));
            check_output("gnt_onehot", 32'($onehot0(GNT)), 32'd1);
            check_output("fin_implies_gnt", 32'(FIN & ~GNT), 32'd0);
`ifdef DLY_ARB_WDOG_EN
            check_output("err", 32'(ERR), 32'(m_err));
`endif
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int c = 0;
        while (BUSY && c < bound) begin
            @(negedge CLK);
            c++;
        end
        check_output(name, 32'(BUSY), 32'd0);
    endtask

    task automatic wait_fin_any(input string name, input int bound, output int cyc);
        cyc = 0;
        while (FIN == '0 && cyc < bound) begin
            @(negedge CLK);
            cyc++;
        end
        check_output(name, 32'(FIN != '0), 32'd1);
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                REQ_MS[12*i +: 12] = 12'($urandom_range(3, 0));
                if (!REQ[i]) begin
                    if ($urandom_range(3, 0) == 0) REQ[i] = 1'b1;
                end else if (FIN[i]) begin
                    if ($urandom_range(1, 0) == 0) REQ[i] = 1'b0;
                end else if (GNT[i]) begin
                    if ($urandom_range(29, 0) == 0) REQ[i] = 1'b0;
                end
            end
        end
    endtask

    int cyc;
    int w;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge CLK);
        check_output("rst_gnt", 32'(GNT), 32'd0);
        check_output("rst_fin", 32'(FIN), 32'd0);
        check_output("rst_tmr_en", 32'(TMR_EN), 32'd0);
        check_output("rst_tmr_ms", 32'(TMR_MS), 32'd0);
        check_output("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Single 3 ms request with 100 cycles per ms
        ms_cycles = 100;
        REQ_MS[11:0] = 12'd3;
        REQ = 4'b0001;
        @(negedge CLK);
        check_output("single_gnt", 32'(GNT), 32'h1);
        check_output("single_tmr_ms", 32'(TMR_MS), 32'd3);
        check_output("single_tmr_en", 32'(TMR_EN), 32'd1);
        REQ_MS[11:0] = 12'd9;
        wait_fin_any("single_fin_seen", 400, cyc);
        check_output("single_fin_latency", 32'(cyc), 32'd301);
        check_output("single_fin_idx", 32'(FIN), 32'h1);
        REQ = '0;
        wait_idle("single_idle", 5);

        // Abort requester 2 mid-run, then confirm it was recorded as last owner
        ms_cycles = 4;
        REQ_MS[35:24] = 12'd5;
        REQ = 4'b0100;
        @(negedge CLK);
        check_output("abort_gnt", 32'(GNT), 32'h4);
        repeat (3) @(negedge CLK);
        REQ[2] = 1'b0;
        @(negedge CLK);
        check_output("abort_tmr_en", 32'(TMR_EN), 32'd0);
        check_output("abort_gnt_clr", 32'(GNT), 32'd0);
        check_output("abort_no_fin", 32'(FIN), 32'd0);
        @(negedge CLK);
        check_output("abort_idle", 32'(BUSY), 32'd0);
        REQ = 4'b1111;
        @(negedge CLK);
        check_output("after_abort_gnt3", 32'(GNT), 32'h8);
        REQ = '0;
        wait_idle("after_abort_idle", 10);

        // Zero-length delay
        REQ_MS[23:12] = 12'd0;
        REQ = 4'b0010;
        @(negedge CLK);
        check_output("zero_gnt", 32'(GNT), 32'h2);
        wait_fin_any("zero_fin_seen", 10, cyc);
        check_output("zero_fin_within2", 32'(cyc <= 2), 32'd1);
        REQ = '0;
        cyc = 0;
        while (BUSY && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        check_output("zero_busy_fall", 32'(cyc), 32'd2);

        // Asynchronous reset in the middle of a run
        REQ_MS[47:36] = 12'd10;
        REQ = 4'b1000;
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check_output("arst_gnt", 32'(GNT), 32'd0);
        check_output("arst_tmr_en", 32'(TMR_EN), 32'd0);
        check_output("arst_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);

        // Round robin from reset with all four held
        for (int i = 0; i < N; i++) REQ_MS[12*i +: 12] = 12'd1;
        REQ = 4'b1111;
        RST = 1'b1;
        @(negedge CLK);
        check_output("rr_first_gnt", 32'(GNT), 32'h1);
        for (int t = 0; t < 5; t++) begin
            wait_fin_any("rr_fin_seen", 50, cyc);
            w = 0;
            for (int i = 0; i < N; i++) if (FIN[i]) w = i;
            order[t] = w;
            REQ[w] = 1'b0;
            @(negedge CLK);
            REQ[w] = 1'b1;
        end
        for (int t = 0; t < 5; t++) check_output("rr_order", 32'(order[t]), 32'(exp_order[t]));
        REQ = '0;
        wait_idle("rr_idle", 20);

`ifdef DLY_ARB_WDOG_EN
        // Watchdog with a timer that never finishes
        tmr_dead = 1'b1;
        REQ = 4'b0001;
        @(negedge CLK);
        cyc = 0;
        while (!ERR && cyc < int'(WDOG) + 20) begin
            @(negedge CLK);
            cyc++;
        end
        check_output("wdog_latency", 32'(cyc), WDOG);
        check_output("wdog_gnt_clr", 32'(GNT), 32'd0);
        @(negedge CLK);
        check_output("wdog_err_pulse", 32'(ERR), 32'd0);
        check_output("wdog_idle", 32'(BUSY), 32'd0);
        REQ = '0;
        tmr_dead = 1'b0;
        repeat (2) @(negedge CLK);
`endif

        // Random traffic against the model
        ms_cycles = 3;
        apply_stimulus(800);
        REQ = '0;
        wait_idle("random_idle", 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
